// File: rtl/alu_vector_gen.sv
// Self-checking ALU vector source: sweeps ops 0..7 over LFSR or fixed operand
// pairs, attaches the golden result and NZVC flags, then appends illegal-op vectors.
module alu_vector_gen #(
    parameter int XLEN  = 32,
    parameter int N_BAD = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            mode,
    input  logic [31:0]     seed,
    input  logic [15:0]     count,
    input  logic [XLEN-1:0] a_in,
    input  logic [XLEN-1:0] b_in,
    output logic            vld,
    input  logic            rdy,
    output logic [XLEN-1:0] a,
    output logic [XLEN-1:0] b,
    output logic [3:0]      op,
    output logic [XLEN-1:0] sexp,
    output logic            nexp,
    output logic            zexp,
    output logic            vexp,
    output logic            cexp,
    output logic            hexp,
    output logic            busy,
    output logic            done
);
    localparam int          SHW  = $clog2(XLEN);
    localparam logic [31:0] TAPS = 32'h8020_0003;
    localparam logic [2:0]  NB   = 3'(N_BAD);

    typedef enum logic [2:0] {IDLE, LOAD, GEN, BAD, FIN} state_t;

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [3:0]      op;
        logic [XLEN-1:0] s;
        logic            n, z, v, c, h;
    } vec_t;

    function automatic logic [31:0] lfsr_step(input logic [31:0] x);
        return (x >> 1) ^ (x[0] ? TAPS : 32'h0);
    endfunction

    function automatic vec_t mk_legal(input logic [XLEN-1:0] ra, input logic [XLEN-1:0] rb,
                                      input logic [2:0] rop);
        vec_t            r;
        logic [XLEN:0]   w;
        logic [SHW-1:0]  sh;
        r    = '0;
        w    = '0;
        r.a  = ra;
        r.b  = rb;
        r.op = {1'b0, rop};
        sh   = rb[SHW-1:0];
        case (rop)
            3'd0: begin
                w   = {1'b0, ra} + {1'b0, rb};
                r.s = w[XLEN-1:0];
                r.c = w[XLEN];
                r.v = (ra[XLEN-1] == rb[XLEN-1]) && (r.s[XLEN-1] != ra[XLEN-1]);
            end
            3'd1: begin
                // Subtract as a + ~b + 1 so the carry-out is the not-borrow flag
                w   = {1'b0, ra} + {1'b0, ~rb} + (XLEN+1)'(1);
                r.s = w[XLEN-1:0];
                r.c = w[XLEN];
                r.v = (ra[XLEN-1] != rb[XLEN-1]) && (r.s[XLEN-1] != ra[XLEN-1]);
            end
            3'd2:    r.s = ra & rb;
            3'd3:    r.s = ra | rb;
            3'd4:    r.s = ra ^ rb;
            3'd5:    r.s = ra << sh;
            3'd6:    r.s = ra >> sh;
            default: r.s = XLEN'($signed(ra) >>> sh);
        endcase
        r.n = r.s[XLEN-1];
        r.z = (r.s == '0);
        return r;
    endfunction

    function automatic vec_t mk_bad(input logic [XLEN-1:0] ra, input logic [XLEN-1:0] rb,
                                    input logic [2:0] k);
        vec_t r;
        r    = '0;
        r.a  = ra;
        r.b  = rb;
        r.op = {1'b1, k};
        r.h  = 1'b1;
        return r;
    endfunction

    state_t          state_q, state_d;
    logic            mode_q, mode_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [15:0]     pair_q, pair_d;
    logic [2:0]      opc_q, opc_d;
    logic [2:0]      badk_q, badk_d;
    logic [31:0]     lfsr_q, lfsr_d;
    logic [XLEN-1:0] pa_q, pa_d, pb_q, pb_d;
    logic            vld_q, vld_d;
    vec_t            out_q, out_d;

    logic            load_en;
    logic [31:0]     l1, l2;
    logic [XLEN-1:0] npa, npb;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        pair_d  = pair_q;
        opc_d   = opc_q;
        badk_d  = badk_q;
        lfsr_d  = lfsr_q;
        pa_d    = pa_q;
        pb_d    = pb_q;
        vld_d   = vld_q;
        out_d   = out_q;
        // Output register refills when empty or as its vector leaves
        load_en = !vld_q || rdy;
        l1      = lfsr_step(lfsr_q);
        l2      = lfsr_step(l1);
        npa     = mode_q ? a_in : l1[XLEN-1:0];
        npb     = mode_q ? b_in : l2[XLEN-1:0];

        case (state_q)
            IDLE: if (start) begin
                state_d = LOAD;
                mode_d  = mode;
                cnt_d   = count;
                lfsr_d  = (seed == 32'h0) ? 32'h1 : seed;
                pair_d  = '0;
                opc_d   = '0;
                badk_d  = '0;
                pa_d    = '0;
                pb_d    = '0;
            end
            LOAD: begin
                if (cnt_q != 16'h0) begin
                    out_d   = mk_legal(npa, npb, 3'd0);
                    vld_d   = 1'b1;
                    pa_d    = npa;
                    pb_d    = npb;
                    lfsr_d  = mode_q ? lfsr_q : l2;
                    pair_d  = 16'd1;
                    opc_d   = 3'd1;
                    state_d = GEN;
                end else if (NB != 3'd0) begin
                    out_d   = mk_bad('0, '0, 3'd0);
                    vld_d   = 1'b1;
                    badk_d  = 3'd1;
                    state_d = BAD;
                end else begin
                    state_d = FIN;
                end
            end
            GEN: if (load_en) begin
                if (opc_q != 3'd0) begin
                    out_d = mk_legal(pa_q, pb_q, opc_q);
                    vld_d = 1'b1;
                    opc_d = opc_q + 3'd1;
                end else if (pair_q != cnt_q) begin
                    out_d  = mk_legal(npa, npb, 3'd0);
                    vld_d  = 1'b1;
                    pa_d   = npa;
                    pb_d   = npb;
                    lfsr_d = mode_q ? lfsr_q : l2;
                    pair_d = pair_q + 16'd1;
                    opc_d  = 3'd1;
                end else if (NB != 3'd0) begin
                    out_d   = mk_bad(pa_q, pb_q, 3'd0);
                    vld_d   = 1'b1;
                    badk_d  = 3'd1;
                    state_d = BAD;
                end else begin
                    vld_d   = 1'b0;
                    state_d = FIN;
                end
            end
            BAD: if (load_en) begin
                if (badk_q != NB) begin
                    out_d  = mk_bad(pa_q, pb_q, badk_q);
                    vld_d  = 1'b1;
                    badk_d = badk_q + 3'd1;
                end else begin
                    vld_d   = 1'b0;
                    state_d = FIN;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            cnt_q   <= '0;
            pair_q  <= '0;
            opc_q   <= '0;
            badk_q  <= '0;
            lfsr_q  <= 32'h1;
            pa_q    <= '0;
            pb_q    <= '0;
            vld_q   <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            pair_q  <= pair_d;
            opc_q   <= opc_d;
            badk_q  <= badk_d;
            lfsr_q  <= lfsr_d;
            pa_q    <= pa_d;
            pb_q    <= pb_d;
            vld_q   <= vld_d;
            out_q   <= out_d;
        end
    end

    assign vld  = vld_q;
    assign a    = out_q.a;
    assign b    = out_q.b;
    assign op   = out_q.op;
    assign sexp = out_q.s;
    assign nexp = out_q.n;
    assign zexp = out_q.z;
    assign vexp = out_q.v;
    assign cexp = out_q.c;
    assign hexp = out_q.h;
    assign busy = (state_q == LOAD) || (state_q == GEN) || (state_q == BAD);
    assign done = (state_q == FIN);
endmodule

// File: tb/tb_alu_vector_gen.sv
// Bench for alu_vector_gen: a reference LFSR/ALU model fills a queue of expected
// vectors per run; every accepted vector is popped and compared.
module tb_alu_vector_gen;
    localparam int XLEN  = 32;
    localparam int N_BAD = 2;

    logic            clk = 1'b0;
    logic            rst, start, mode, rdy;
    logic [31:0]     seed;
    logic [15:0]     count;
    logic [XLEN-1:0] a_in, b_in, a, b, sexp;
    logic [3:0]      op;
    logic            vld, nexp, zexp, vexp, cexp, hexp, busy, done;

    always #5 clk = ~clk;

    alu_vector_gen #(.XLEN(XLEN), .N_BAD(N_BAD)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .seed(seed), .count(count),
        .a_in(a_in), .b_in(b_in), .vld(vld), .rdy(rdy), .a(a), .b(b), .op(op),
        .sexp(sexp), .nexp(nexp), .zexp(zexp), .vexp(vexp), .cexp(cexp), .hexp(hexp),
        .busy(busy), .done(done)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [31:0] s;
        logic        n, z, v, c, h;
    } ev_t;

    ev_t exp_q[$];
    ev_t log_q[$];
    ev_t obs;
    ev_t held;
    logic stall = 1'b0;
    int total = 0;
    int bad   = 0;
    int done_cnt = 0;

    assign obs = {a, b, op, sexp, nexp, zexp, vexp, cexp, hexp};

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
        total++;
        assert (got === want)
        else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] step(input logic [31:0] x);
        logic [31:0] r;
        r = {1'b0, x[31:1]};
        if (x[0]) r = r ^ 32'h8020_0003;
        return r;
    endfunction

    function automatic ev_t mdl(input logic [31:0] ra, input logic [31:0] rb, input int o);
        ev_t r;
        longint unsigned ua, ub, full;
        longint sa, sb, sr;
        r    = '0;
        r.a  = ra;
        r.b  = rb;
        r.op = 4'(o);
        ua = {32'h0, ra};
        ub = {32'h0, rb};
        sa = longint'($signed(ra));
        sb = longint'($signed(rb));
        case (o)
            0: begin
                full = ua + ub;
                r.s  = full[31:0];
                r.c  = full[32];
                sr   = sa + sb;
                r.v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            1: begin
                r.s = ra - rb;
                r.c = (ra >= rb);
                sr  = sa - sb;
                r.v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            2: r.s = ra & rb;
            3: r.s = ra | rb;
            4: r.s = ra ^ rb;
            5: r.s = ra << rb[4:0];
            6: r.s = ra >> rb[4:0];
            default: begin
                sr  = sa >> rb[4:0];
                r.s = sr[31:0];
            end
        endcase
        r.n = r.s[31];
        r.z = (r.s == 32'h0);
        return r;
    endfunction

    task automatic push_run(input logic m, input logic [31:0] sd, input int cnt,
                            input logic [31:0] ai, input logic [31:0] bi);
        logic [31:0] l, pa, pb;
        ev_t e;
        l  = (sd == 32'h0) ? 32'h1 : sd;
        pa = 32'h0;
        pb = 32'h0;
        for (int p = 0; p < cnt; p++) begin
            if (m) begin
                pa = ai;
                pb = bi;
            end else begin
                l  = step(l);
                pa = l;
                l  = step(l);
                pb = l;
            end
            for (int o = 0; o < 8; o++) exp_q.push_back(mdl(pa, pb, o));
        end
        for (int k = 0; k < N_BAD; k++) begin
            e    = '0;
            e.a  = pa;
            e.b  = pb;
            e.op = 4'(8 + k);
            e.h  = 1'b1;
            exp_q.push_back(e);
        end
    endtask

    // Monitor: checks hold-while-stalled and scoreboards each accepted vector
    always @(negedge clk) begin
        ev_t e;
        if (rst) begin
            stall <= 1'b0;
        end else begin
            if (stall) chk("hold", {vld, obs}, {1'b1, held});
            stall <= vld && !rdy;
            held  <= obs;
            if (vld && rdy) begin
                log_q.push_back(obs);
                total++;
                assert (exp_q.size() > 0)
                else begin
                    bad++;
                    $error("FAIL extra_vec got=%0h exp=none", obs);
                end
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("vec", obs, e);
                end
            end
            if (done) done_cnt++;
        end
    end

    task automatic start_run(input logic m, input logic [31:0] sd, input int cnt,
                             input logic [31:0] ai, input logic [31:0] bi,
                             input logic rdy0, input logic poke);
        push_run(m, sd, cnt, ai, bi);
        log_q.delete();
        mode  = m;
        seed  = sd;
        count = 16'(cnt);
        a_in  = ai;
        b_in  = bi;
        @(posedge clk); #1;
        start = 1'b1;
        rdy   = rdy0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("lat_vld_t1", vld, 0);
        chk("lat_busy_t1", busy, 1);
        @(posedge clk); #1;
        chk("lat_vld_t2", vld, 1);
        if (poke) start = 1'b1;
    endtask

    task automatic wait_done(input int pct, output int n);
        int d0;
        d0 = done_cnt;
        n  = 0;
        while (1) begin
            @(posedge clk); #1;
            start = 1'b0;
            n++;
            if (done || n > 5000) break;
            rdy = ($urandom_range(99) < pct);
        end
        total++;
        assert (n <= 5000)
        else begin
            bad++;
            $error("FAIL timeout got=%0d exp<=5000", n);
        end
        chk("busy_at_done", busy, 0);
        @(posedge clk); #1;
        chk("done_1cyc", done, 0);
        chk("done_pulses", done_cnt - d0, 1);
        chk("queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; mode = 1'b0; rdy = 1'b0;
        seed = '0; count = '0; a_in = '0; b_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_vld", vld, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_fields", obs, 0);
        rst = 1'b0;

        // Fixed operands: overflow / carry corner
        start_run(1'b1, 32'h0, 1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 1'b0);
        wait_done(100, n);
        chk("fix_cycles", n, 10);
        chk("fix_nvec", log_q.size(), 10);
        chk("add_s", log_q[0].s, 32'h8000_0000);
        chk("add_nzvc", {log_q[0].n, log_q[0].z, log_q[0].v, log_q[0].c}, 4'b1010);
        chk("sub_s", log_q[1].s, 32'h7FFF_FFFE);
        chk("sub_nzvc", {log_q[1].n, log_q[1].z, log_q[1].v, log_q[1].c}, 4'b0001);
        chk("sll_s", log_q[5].s, 32'hFFFF_FFFE);
        chk("bad0", {log_q[8].op, log_q[8].h, log_q[8].s}, {4'b1000, 1'b1, 32'h0});
        chk("bad1", {log_q[9].op, log_q[9].h, log_q[9].s}, {4'b1001, 1'b1, 32'h0});

        // Equal operands: zero results and no-borrow
        start_run(1'b1, 32'h0, 1, 32'h5, 32'h5, 1'b1, 1'b0);
        wait_done(100, n);
        chk("sub0_s", log_q[1].s, 32'h0);
        chk("sub0_nzvc", {log_q[1].n, log_q[1].z, log_q[1].v, log_q[1].c}, 4'b0101);
        chk("xor0_s", log_q[4].s, 32'h0);
        chk("xor0_nzvc", {log_q[4].n, log_q[4].z, log_q[4].v, log_q[4].c}, 4'b0100);
        chk("sra0_s", log_q[7].s, 32'h0);

        // Sign-bit shifts by 31
        start_run(1'b1, 32'h0, 1, 32'h8000_0000, 32'h0000_001F, 1'b1, 1'b0);
        wait_done(100, n);
        chk("sra_s", log_q[7].s, 32'hFFFF_FFFF);
        chk("sra_n", log_q[7].n, 1);
        chk("srl_s", log_q[6].s, 32'h1);

        // LFSR operands under random backpressure; seed 0 acts as seed 1
        start_run(1'b0, 32'h0, 5, 32'h0, 32'h0, 1'b0, 1'b0);
        wait_done(30, n);
        chk("bp_nvec", log_q.size(), 42);
        chk("seed0_a", log_q[0].a, 32'h8020_0003);
        chk("seed0_b", log_q[0].b, 32'hC030_0002);

        // Reset in the middle of a run, then replay
        start_run(1'b0, 32'h1234_5678, 3, 32'h0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 50; i++) begin
            if (log_q.size() >= 5) break;
            @(posedge clk); #1;
        end
        chk("mid_accepted", log_q.size(), 5);
        rst = 1'b1;
        rdy = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_vld", vld, 0);
        chk("mid_rst_busy", busy, 0);
        exp_q.delete();
        start_run(1'b0, 32'h1234_5678, 3, 32'h0, 32'h0, 1'b1, 1'b0);
        wait_done(100, n);
        chk("replay_nvec", log_q.size(), 26);

        // count = 0: only bad vectors, zero operands; start while busy ignored
        start_run(1'b0, 32'h0, 0, 32'h0, 32'h0, 1'b1, 1'b1);
        wait_done(100, n);
        chk("c0_nvec", log_q.size(), 2);
        chk("c0_v0", {log_q[0].a, log_q[0].b, log_q[0].op}, {64'h0, 4'b1000});
        chk("c0_v1", {log_q[1].a, log_q[1].b, log_q[1].op}, {64'h0, 4'b1001});
        repeat (3) @(posedge clk);
        #1;
        chk("c0_idle_vld", vld, 0);
        chk("c0_idle_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
